shift_sub_divider: RTL

- Sequential unsigned restoring divider, the inverse of the team's shift-add multiplier: i_dividend / i_divisor gives quotient and remainder.
- Produces one quotient bit per clock using shift-and-subtract, for a latency of WIDTH+1 cycles.
- Sits beside the multiplier in the arithmetic datapath.
- A start/busy/valid handshake lets a controller issue one operation at a time.

---
 rtl/shift_sub_divider_pkg.sv | 23 ++
 rtl/shift_sub_divider_div_step.sv | 30 +++
 rtl/shift_sub_divider.sv | 109 ++++++++++
 3 files changed

// File: rtl/shift_sub_divider_pkg.sv
// Shared arithmetic definitions for the shift/subtract divider: FSM states,
// counter sizing and the divide-by-zero quotient.
package shift_sub_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 4;

   // Counter must hold 0..width, so it needs clog2(width+1) bits.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

   // Divide-by-zero quotient: all ones at the given width.
   function automatic logic [31:0] dbz_quotient(input int width);
      return (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
   endfunction

endpackage

// File: rtl/shift_sub_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, then subtract the divisor if it fits.
module shift_sub_divider_div_step #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic             dividend_msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] divisor_ext;

   // rem_in is always below divisor, so its top bit is zero and dropping it
   // in the shift loses nothing.
   assign shifted     = {rem_in[WIDTH-1:0], dividend_msb};
   assign divisor_ext = {1'b0, divisor};

   always_comb begin
      rem_out = shifted;
      q_bit   = 1'b0;
      if (shifted >= divisor_ext) begin
         rem_out = shifted - divisor_ext;
         q_bit   = 1'b1;
      end
   end

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Handshake: i_start is accepted only when o_busy=0; o_valid pulses for one cycle when results load.
module shift_sub_divider
   import shift_sub_divider_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_div_by_zero,
   output logic [1:0]       o_state
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] DBZ_Q     = WIDTH'(dbz_quotient(WIDTH));

   state_t           state;
   logic [WIDTH-1:0] dvd_sh;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] quo;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   rem_next;
   logic             q_bit;
   logic [WIDTH-1:0] quo_next;

   shift_sub_divider_div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in       (rem),
      .dividend_msb (dvd_sh[WIDTH-1]),
      .divisor      (dvs),
      .rem_out      (rem_next),
      .q_bit        (q_bit)
   );

   assign quo_next = {quo[WIDTH-2:0], q_bit};
   assign o_state  = state;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state         <= IDLE;
         dvd_sh        <= '0;
         dvs           <= '0;
         rem           <= '0;
         quo           <= '0;
         cnt           <= '0;
         o_busy        <= 1'b0;
         o_valid       <= 1'b0;
         o_quotient    <= '0;
         o_remainder   <= '0;
         o_div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  dvd_sh <= i_dividend;
                  dvs    <= i_divisor;
                  o_busy <= 1'b1;
                  if (i_divisor == '0) begin
                     // Skip the iterations; results load on DONE entry.
                     state         <= DONE;
                     o_valid       <= 1'b1;
                     o_quotient    <= DBZ_Q;
                     o_remainder   <= i_dividend;
                     o_div_by_zero <= 1'b1;
                  end else begin
                     state <= RUN;
                     rem   <= '0;
                     quo   <= '0;
                     cnt   <= '0;
                  end
               end
            end
            RUN: begin
               rem    <= rem_next;
               quo    <= quo_next;
               dvd_sh <= dvd_sh << 1;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST_ITER) begin
                  state         <= DONE;
                  o_valid       <= 1'b1;
                  o_quotient    <= quo_next;
                  o_remainder   <= rem_next[WIDTH-1:0];
                  o_div_by_zero <= 1'b0;
               end
            end
            DONE: begin
               state   <= IDLE;
               o_valid <= 1'b0;
               o_busy  <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               o_valid <= 1'b0;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
